fact_mmio_ctrl: RTL and testbench
=================================

Name: fact_mmio_ctrl

Overview:
Memory-mapped factorial accelerator controller. It is the source of FactData for the system read-data mux (RdSel=2'b10).
- The CPU address decoder steers fact-region stores and loads here.
- The block holds the operand and control/status/result registers.
- A start FSM sequences an iterative multiply datapath, one multiply per cycle.

Parameters:
w, 32, data/result width (bus word)
NW, 4, operand n width
MAXN, 12, largest n whose factorial fits in w bits; n > MAXN flags an error

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
WE  input  1  write strobe from address decoder (fact region selected and MemWrite)
A  input  2  word select within fact region (byte address bits [3:2])
WD  input  w  write data from CPU
RD  output  w  read data to system output mux (FactData)
Done  output  1  sticky completion flag
Err  output  1  sticky error flag (n > MAXN)

Behaviour:
- Register map, selected by A:
  - 00 N: RW, bits [NW-1:0]; upper bits read 0.
  - 01 GO: write WD[0]=1 to start; reads {0, Busy}.
  - 10 STATUS: RO, {0, Err, Done}.
  - 11 RESULT: RO, w bits.
- RD is combinational from A and the registers, with zero wait states; reads have no side effects.
- Writes take effect at the rising clk edge when WE=1. Writes to read-only addresses are ignored.
- N may be written at any time. Its value is sampled only at start.
- Reset (rst=0, async): state=IDLE; N, cnt, prod, RESULT = 0; Done=0; Err=0; Busy=0. Reset mid-operation aborts with no partial result retained.
- FSM states: IDLE, CHECK, MUL, FIN. Busy=1 in CHECK and MUL.
  - IDLE: WE & A=01 & WD[0] -> CHECK. Load cnt=N, prod=1; clear Done, Err.
  - CHECK:
    - N > MAXN -> FIN with Err=1, RESULT=0.
    - else cnt <= 1 -> FIN with RESULT=1.
    - else -> MUL.
  - MUL: each edge prod <= prod*cnt (truncated to w bits) and cnt <= cnt-1. When cnt==2 at the edge -> FIN with RESULT <= prod*2.
  - FIN: Done=1 (with Err as set); -> IDLE on the next edge. Done and Err stay sticky until the next start or reset.
- Latency, counted from the GO-write edge (edge 0):
  - Done is visible after edge 1 for n <= 1 or n > MAXN.
  - Otherwise Done is visible after edge n.
- GO written while Busy: ignored, with no restart and no flag change.
- GO written in FIN: ignored (a start is accepted only in IDLE).
- Writing GO with WD[0]=0: no effect.
- A start and an N write in the same cycle cannot occur, because they are different addresses.
- RESULT changes only on FIN entry. During an operation the previous RESULT stays readable.
- Product overflow cannot occur for n <= MAXN. The multiplier is w x NW -> w, truncated.

Decomposition:
- Shared package fact_pkg:
  - state enum {IDLE, CHECK, MUL, FIN}
  - register offsets FACT_N=2'b00, FACT_GO=2'b01, FACT_ST=2'b10, FACT_RES=2'b11
  - default MAXN
- One natural sub-module, fact_dp: cnt down-counter, prod register, multiplier, and the cnt<=1 / cnt==2 / n>MAXN comparators.
  - Controls from the FSM: load, mul_en.
  - Status back to the FSM: le1, eq2, ovf.
- The top level holds the FSM, the N/RESULT/flag registers and the RD mux.

Test Plan:
- Reset: assert rst=0 mid-run with N=5 busy -> RD at every A reads 0; Done=0, Err=0; after release GO reads 0.
- Write N=5, GO=1 -> Busy for cycles 1..4; Done=1 after edge 5; RESULT=120; Err=0; GO reads 0 after FIN.
- N=0 and N=1 -> Done after edge 1, RESULT=1; N=12 -> Done after edge 12, RESULT=479001600 (0x1C8CFC00).
- N=13 -> Done=1, Err=1 after edge 1, RESULT=0; STATUS reads 0x3.
- N=6 start, then at cycle 2 write N=3 and GO=1 again -> ignored; RESULT=720 after edge 6; N reads 3; a subsequent start yields 6.
- Write RESULT/STATUS addresses with 0xFFFFFFFF -> unchanged; prior RESULT (120) is held through a new run until FIN.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial MMIO controller.
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        MUL   = 2'b10,
        FIN   = 2'b11
    } state_e;

    localparam logic [1:0] FACT_N   = 2'b00;
    localparam logic [1:0] FACT_GO  = 2'b01;
    localparam logic [1:0] FACT_ST  = 2'b10;
    localparam logic [1:0] FACT_RES = 2'b11;

    localparam int MAXN_DEF = 12;

endpackage

// File: rtl/fact_mmio_ctrl_dp.sv
// Factorial datapath: down-counter, running product and comparators.
module fact_dp #(
    parameter int w    = 32,
    parameter int NW   = 4,
    parameter int MAXN = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          mul_en,
    input  logic [NW-1:0] n_in,
    output logic [w-1:0]  mul,
    output logic          le1,
    output logic          eq2,
    output logic          ovf
);

    localparam logic [NW:0] MAXN_V = (NW+1)'(MAXN);

    logic [NW-1:0] cnt_q, cnt_d;
    logic [w-1:0]  prod_q, prod_d;
    logic [w-1:0]  cnt_ext;

    assign cnt_ext = {{(w-NW){1'b0}}, cnt_q};
    assign mul     = prod_q * cnt_ext;
    assign le1     = cnt_q <= NW'(1);
    assign eq2     = cnt_q == NW'(2);
    assign ovf     = {1'b0, cnt_q} > MAXN_V;

    always_comb begin
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (load) begin
            cnt_d  = n_in;
            prod_d = {{(w-1){1'b0}}, 1'b1};
        end else if (mul_en) begin
            prod_d = mul;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

endmodule

// File: rtl/fact_mmio_ctrl.sv
// Memory-mapped factorial accelerator: registers, start FSM, read mux.
module fact_mmio_ctrl
    import fact_pkg::*;
#(
    parameter int w    = 32,
    parameter int NW   = 4,
    parameter int MAXN = MAXN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         WE,
    input  logic [1:0]   A,
    input  logic [w-1:0] WD,
    output logic [w-1:0] RD,
    output logic         Done,
    output logic         Err
);

    state_e        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [w-1:0]  res_q, res_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          load, mul_en;
    logic          le1, eq2, ovf;
    logic [w-1:0]  mul;
    logic          start;
    logic          unused_wd;

    assign unused_wd = ^WD[w-1:NW];

    assign start = WE && (A == FACT_GO) && WD[0] && (state_q == IDLE);

    fact_dp #(
        .w   (w),
        .NW  (NW),
        .MAXN(MAXN)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .mul_en(mul_en),
        .n_in  (n_q),
        .mul   (mul),
        .le1   (le1),
        .eq2   (eq2),
        .ovf   (ovf)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        res_d   = res_q;
        done_d  = done_q;
        err_d   = err_q;
        load    = 1'b0;
        mul_en  = 1'b0;
        if (WE && (A == FACT_N)) begin
            n_d = WD[NW-1:0];
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CHECK;
                    load    = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            CHECK: begin
                if (ovf) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    res_d   = '0;
                end else if (le1) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    res_d   = {{(w-1){1'b0}}, 1'b1};
                end else begin
                    state_d = MUL;
                end
            end
            MUL: begin
                mul_en = 1'b1;
                // cnt==2 is the last factor; the product lands in RESULT
                if (eq2) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    res_d   = mul;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CHECK) || (state_d == MUL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            res_q   <= res_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        RD = '0;
        unique case (A)
            FACT_N:   RD = {{(w-NW){1'b0}}, n_q};
            FACT_GO:  RD = {{(w-1){1'b0}}, busy_q};
            FACT_ST:  RD = {{(w-2){1'b0}}, err_q, done_q};
            FACT_RES: RD = res_q;
            default:  RD = '0;
        endcase
    end

    assign Done = done_q;
    assign Err  = err_q;

endmodule

// File: tb/tb_fact_mmio_ctrl.sv
// Scoreboard bench for the factorial MMIO controller.
module tb_fact_mmio_ctrl;

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        WE;
    logic [1:0]  A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Done;
    logic        Err;

    int   cyc;
    int   go_cyc;
    int   last_wr_cyc;
    int   n_chk;
    int   n_pass;
    exp_t sb[$];

    fact_mmio_ctrl dut (
        .clk (clk),
        .rst (rst),
        .WE  (WE),
        .A   (A),
        .WD  (WD),
        .RD  (RD),
        .Done(Done),
        .Err (Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fact_model(input int n);
        logic [31:0] r;
        r = 32'd1;
        if (n > 12) return 32'd0;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    function automatic int lat_model(input int n);
        if (n <= 1 || n > 12) return 1;
        return n;
    endfunction

    function automatic int busy_model(input int n);
        if (n <= 1 || n > 12) return 0;
        return n - 1;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        WE = 1'b1;
        A  = a;
        WD = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
        WD = '0;
        last_wr_cyc = cyc;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        A = a;
        #1;
        d = RD;
    endtask

    task automatic push_exp(input int n);
        exp_t e;
        e.res = fact_model(n);
        e.err = (n > 12);
        sb.push_back(e);
    endtask

    task automatic start(input int n);
        wr(2'b00, 32'(n));
        wr(2'b01, 32'd1);
        go_cyc = last_wr_cyc;
        push_exp(n);
    endtask

    task automatic wait_done(input int exp_lat, input int exp_busy);
        logic [31:0] d;
        int   busy_n;
        int   lat;
        bit   seen;
        exp_t e;
        busy_n = 0;
        lat    = -1;
        seen   = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (Done) begin
                seen = 1;
                lat  = cyc - go_cyc;
            end else begin
                rd(2'b01, d);
                if (d[0]) busy_n++;
            end
        end
        n_chk++;
        if (lat !== exp_lat)
            $display("FAIL latency: got %0d want %0d", lat, exp_lat);
        else
            n_pass++;
        n_chk++;
        if (busy_n !== exp_busy)
            $display("FAIL busy_cycles: got %0d want %0d", busy_n, exp_busy);
        else
            n_pass++;
        n_chk++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            n_pass++;
            e = sb.pop_front();
            rd(2'b11, d);
            n_chk++;
            if (d !== e.res)
                $display("FAIL result: got 0x%08h want 0x%08h", d, e.res);
            else
                n_pass++;
            rd(2'b10, d);
            n_chk++;
            if (d !== {30'd0, e.err, 1'b1})
                $display("FAIL status: got 0x%08h want 0x%08h",
                         d, {30'd0, e.err, 1'b1});
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_init;
        logic [31:0] d;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_chk++;
            if (d !== 32'd0)
                $display("FAIL init_rd_a%0d: got 0x%08h want 0", a, d);
            else
                n_pass++;
        end
        n_chk++;
        if ({Done, Err} !== 2'b00)
            $display("FAIL init_flags: got %b want 00", {Done, Err});
        else
            n_pass++;
    endtask

    task automatic test_basic;
        logic [31:0] d;
        start(5);
        wait_done(5, 4);
        n_chk++;
        if (Err !== 1'b0)
            $display("FAIL basic_err: got %b want 0", Err);
        else
            n_pass++;
        @(posedge clk);
        #1;
        rd(2'b01, d);
        n_chk++;
        if (d !== 32'd0)
            $display("FAIL basic_go_after_fin: got 0x%08h want 0", d);
        else
            n_pass++;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        start(5);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        sb.delete();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_chk++;
            if (d !== 32'd0)
                $display("FAIL rst_rd_a%0d: got 0x%08h want 0", a, d);
            else
                n_pass++;
        end
        n_chk++;
        if ({Done, Err} !== 2'b00)
            $display("FAIL rst_flags: got %b want 00", {Done, Err});
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd(2'b01, d);
        n_chk++;
        if (d !== 32'd0)
            $display("FAIL rst_go_after: got 0x%08h want 0", d);
        else
            n_pass++;
    endtask

    task automatic test_edges;
        int ns[5];
        ns = '{0, 1, 12, 13, 2};
        foreach (ns[i]) begin
            start(ns[i]);
            wait_done(lat_model(ns[i]), busy_model(ns[i]));
            n_chk++;
            if (Err !== (ns[i] > 12))
                $display("FAIL edge_err_n%0d: got %b want %b",
                         ns[i], Err, (ns[i] > 12));
            else
                n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] d;
        start(6);
        wr(2'b00, 32'd3);
        wr(2'b01, 32'd1);
        wait_done(6, 3);
        rd(2'b00, d);
        n_chk++;
        if (d !== 32'd3)
            $display("FAIL ign_n_read: got 0x%08h want 3", d);
        else
            n_pass++;
        @(posedge clk);
        #1;
        wr(2'b01, 32'd1);
        go_cyc = last_wr_cyc;
        push_exp(3);
        wait_done(3, 2);
        @(posedge clk);
        #1;
    endtask

    task automatic test_ro_writes;
        logic [31:0] d;
        start(5);
        wait_done(5, 4);
        @(posedge clk);
        #1;
        wr(2'b11, 32'hFFFF_FFFF);
        wr(2'b10, 32'hFFFF_FFFF);
        rd(2'b11, d);
        n_chk++;
        if (d !== 32'd120)
            $display("FAIL ro_result: got 0x%08h want 0x%08h", d, 32'd120);
        else
            n_pass++;
        rd(2'b10, d);
        n_chk++;
        if (d !== 32'd1)
            $display("FAIL ro_status: got 0x%08h want 1", d);
        else
            n_pass++;
        start(4);
        rd(2'b11, d);
        n_chk++;
        if (d !== 32'd120)
            $display("FAIL hold_result0: got 0x%08h want 0x%08h", d, 32'd120);
        else
            n_pass++;
        @(posedge clk);
        #1;
        rd(2'b11, d);
        n_chk++;
        if (d !== 32'd120)
            $display("FAIL hold_result1: got 0x%08h want 0x%08h", d, 32'd120);
        else
            n_pass++;
        wait_done(4, 2);
        @(posedge clk);
        #1;
    endtask

    task automatic test_go_fin;
        logic [31:0] d;
        start(2);
        wait_done(2, 1);
        wr(2'b01, 32'd1);
        rd(2'b01, d);
        n_chk++;
        if ({d, Done} !== {32'd0, 1'b1})
            $display("FAIL fin_go: got busy=%0d done=%b want busy=0 done=1",
                     d, Done);
        else
            n_pass++;
        @(posedge clk);
        #1;
        rd(2'b01, d);
        n_chk++;
        if ({d, Done} !== {32'd0, 1'b1})
            $display("FAIL fin_go_late: got busy=%0d done=%b want 0/1",
                     d, Done);
        else
            n_pass++;
        wr(2'b01, 32'd0);
        @(posedge clk);
        #1;
        rd(2'b01, d);
        n_chk++;
        if ({d, Done} !== {32'd0, 1'b1})
            $display("FAIL go_zero: got busy=%0d done=%b want 0/1", d, Done);
        else
            n_pass++;
        rd(2'b11, d);
        n_chk++;
        if (d !== 32'd2)
            $display("FAIL go_zero_result: got 0x%08h want 2", d);
        else
            n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        WE     = 1'b0;
        A      = 2'b00;
        WD     = '0;
        go_cyc = 0;
        last_wr_cyc = 0;
        #12;
        test_reset_init();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_reset();
        test_edges();
        test_busy_ignore();
        test_ro_writes();
        test_go_fin();
        n_chk++;
        if (sb.size() !== 0)
            $display("FAIL sb_leftover: got %0d want 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
